tff_counter_ctrl: RTL and testbench

- Sequencing controller for a W-bit bank of T flip-flops (`tff` cells: t, clk, clear, q, qb) that together form a ripple-free synchronous counter.
- Drives every cell's t input and the shared bank clear. Reads the bank's q outputs back.
- Supports start/stop, up/down direction, programmable modulus, free-run or one-shot, and a terminal-count pulse.
- Sits between the CPU control unit and the counter datapath.

---
 rtl/tff_counter_ctrl.sv | 123 ++++++++++++
 tb/tb_tff_counter_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tff_counter_ctrl.sv
// rtl/tff_counter_ctrl.sv - sequencing controller for a W-bit synchronous TFF counter bank
// Drives toggle enables and bank clear from a four-state FSM; terminal count pulses tc.
module tff_counter_ctrl #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         start,
    input  logic         stop,
    input  logic         dir,
    input  logic         oneshot,
    input  logic [W-1:0] mod_val,
    input  logic [W-1:0] q_in,
    output logic [W-1:0] t_out,
    output logic         bank_clear,
    output logic         tc,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_HALT = 2'b11
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [W-1:0]   r_mod_lat;
    logic           r_dir_lat;
    logic           r_os_lat;
    logic           w_accept;
    logic           w_term;
    logic [W-1:0]   w_up_t;
    logic [W-1:0]   w_dn_t;
    logic           w_up_acc;
    logic           w_dn_acc;

    // A start is only honoured from a resting state; stop always wins.
    assign w_accept = ((r_state == S_IDLE) || (r_state == S_HALT)) && start && !stop;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state   <= S_IDLE;
            r_mod_lat <= '0;
            r_dir_lat <= 1'b0;
            r_os_lat  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_mod_lat <= mod_val;
                r_dir_lat <= dir;
                r_os_lat  <= oneshot;
            end
        end
    end

    // Bit i toggles when all lower bits are 1 (up) or all lower bits are 0 (down).
    always_comb begin
        w_up_t   = '0;
        w_dn_t   = '0;
        w_up_acc = 1'b1;
        w_dn_acc = 1'b1;
        for (int i = 0; i < W; i++) begin
            w_up_t[i] = w_up_acc;
            w_dn_t[i] = w_dn_acc;
            w_up_acc  = w_up_acc & q_in[i];
            w_dn_acc  = w_dn_acc & ~q_in[i];
        end
    end

    assign w_term = r_dir_lat ? (q_in == r_mod_lat) : (q_in == '0);

    always_comb begin
        w_next     = r_state;
        t_out      = '0;
        bank_clear = 1'b0;
        tc         = 1'b0;
        busy       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_LOAD;
            end
            S_LOAD: begin
                busy = 1'b1;
                if (r_dir_lat) bank_clear = 1'b1;
                else           t_out      = q_in ^ r_mod_lat;
                w_next = stop ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_term) begin
                    tc = 1'b1;
                    if (stop) begin
                        w_next = S_IDLE;
                    end else if (r_os_lat) begin
                        w_next = S_HALT;
                    end else if (r_dir_lat) begin
                        bank_clear = 1'b1;
                    end else begin
                        t_out = q_in ^ r_mod_lat;
                    end
                end else if (stop) begin
                    w_next = S_IDLE;
                end else begin
                    t_out = r_dir_lat ? w_up_t : w_dn_t;
                end
            end
            S_HALT: begin
                if (stop)          w_next = S_IDLE;
                else if (w_accept) w_next = S_LOAD;
            end
            default: w_next = S_IDLE;
        endcase
        if (clear) begin
            t_out      = '0;
            bank_clear = 1'b1;
            tc         = 1'b0;
            busy       = 1'b0;
        end
    end

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// tb/tb_tff_counter_ctrl.sv - directed vector bench for tff_counter_ctrl with a behavioural TFF bank
module tb_tff_counter_ctrl;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       dir = 1'b0;
    logic       oneshot = 1'b0;
    logic [1:0] mod_val = 2'd0;
    logic [1:0] q_bank = 2'd2;
    logic [1:0] t_out;
    logic       bank_clear;
    logic       tc;
    logic       busy;
    logic       poke_en = 1'b0;
    logic [1:0] poke_val = 2'd0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       clr;
        logic       st;
        logic       sp;
        logic       d;
        logic       os;
        logic [1:0] mv;
        logic [1:0] q;
        logic       tc;
        logic       busy;
        logic       bc;
        logic [1:0] t;
    } vec_t;

    vec_t vq[$];

    tff_counter_ctrl #(.W(2)) dut (
        .clk        (clk),
        .clear      (clear),
        .start      (start),
        .stop       (stop),
        .dir        (dir),
        .oneshot    (oneshot),
        .mod_val    (mod_val),
        .q_in       (q_bank),
        .t_out      (t_out),
        .bank_clear (bank_clear),
        .tc         (tc),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Bank of T flip-flops with synchronous clear; poke models an external disturbance.
    always_ff @(posedge clk) begin
        if (poke_en)         q_bank <= poke_val;
        else if (bank_clear) q_bank <= 2'd0;
        else                 q_bank <= q_bank ^ t_out;
    end

    task automatic step(input vec_t v, input string name, input logic pk, input logic [1:0] pv);
        logic [6:0] act;
        logic [6:0] exp;
        @(negedge clk);
        clear    = v.clr;
        start    = v.st;
        stop     = v.sp;
        dir      = v.d;
        oneshot  = v.os;
        mod_val  = v.mv;
        poke_en  = pk;
        poke_val = pv;
        #1;
        act = {q_bank, tc, busy, bank_clear, t_out};
        exp = {v.q, v.tc, v.busy, v.bc, v.t};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got q=%0d tc=%b busy=%b bc=%b t=%b, want q=%0d tc=%b busy=%b bc=%b t=%b",
                     name, act[6:5], act[4], act[3], act[2], act[1:0],
                     exp[6:5], exp[4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    initial begin
        int n;
        // clr st sp d os mv | q tc busy bc t
        vq.push_back('{1,0,0,0,0,0, 0,0,0,1,0});
        vq.push_back('{1,0,0,0,0,0, 0,0,0,1,0});
        vq.push_back('{0,0,0,0,0,0, 0,0,0,0,0});
        // up, mod 2, wrap; terminal+stop at the end
        vq.push_back('{0,1,0,1,0,2, 0,0,0,0,0});
        vq.push_back('{0,0,0,0,0,0, 0,0,1,1,0});
        vq.push_back('{0,0,0,0,0,0, 0,0,1,0,1});
        vq.push_back('{0,1,0,0,0,0, 1,0,1,0,3});
        vq.push_back('{0,0,0,0,0,0, 2,1,1,1,0});
        vq.push_back('{0,0,0,0,0,0, 0,0,1,0,1});
        vq.push_back('{0,0,0,0,0,0, 1,0,1,0,3});
        vq.push_back('{0,0,1,0,0,0, 2,1,1,0,0});
        vq.push_back('{0,0,0,0,0,0, 2,0,0,0,0});
        // down, mod 3, wrap; mid-run input changes ignored; stop non-terminal
        vq.push_back('{0,1,0,0,0,3, 2,0,0,0,0});
        vq.push_back('{0,0,0,1,0,0, 2,0,1,0,1});
        vq.push_back('{0,0,0,1,0,0, 3,0,1,0,1});
        vq.push_back('{0,0,0,1,0,0, 2,0,1,0,3});
        vq.push_back('{0,0,0,1,0,0, 1,0,1,0,1});
        vq.push_back('{0,0,0,1,0,0, 0,1,1,0,3});
        vq.push_back('{0,0,0,1,1,0, 3,0,1,0,1});
        vq.push_back('{0,0,1,0,0,0, 2,0,1,0,0});
        vq.push_back('{0,1,1,1,0,3, 2,0,0,0,0});
        vq.push_back('{0,0,0,0,0,0, 2,0,0,0,0});
        // up, mod 3, one-shot -> HALT holds 5 cycles, restart, stop at q=1
        vq.push_back('{0,1,0,1,1,3, 2,0,0,0,0});
        vq.push_back('{0,0,0,0,0,0, 2,0,1,1,0});
        vq.push_back('{0,0,0,0,0,0, 0,0,1,0,1});
        vq.push_back('{0,0,0,0,0,0, 1,0,1,0,3});
        vq.push_back('{0,0,0,0,0,0, 2,0,1,0,1});
        vq.push_back('{0,0,0,0,0,0, 3,1,1,0,0});
        for (int i = 0; i < 5; i++) vq.push_back('{0,0,0,0,0,0, 3,0,0,0,0});
        vq.push_back('{0,1,0,1,0,3, 3,0,0,0,0});
        vq.push_back('{0,0,0,0,0,0, 3,0,1,1,0});
        vq.push_back('{0,0,0,0,0,0, 0,0,1,0,1});
        vq.push_back('{0,0,1,0,0,0, 1,0,1,0,0});
        vq.push_back('{0,0,0,0,0,0, 1,0,0,0,0});
        // clear mid-run at q=2
        vq.push_back('{0,1,0,1,0,3, 1,0,0,0,0});
        vq.push_back('{0,0,0,0,0,0, 1,0,1,1,0});
        vq.push_back('{0,0,0,0,0,0, 0,0,1,0,1});
        vq.push_back('{0,0,0,0,0,0, 1,0,1,0,3});
        vq.push_back('{1,0,0,0,0,0, 2,0,0,1,0});
        vq.push_back('{0,0,0,0,0,0, 0,0,0,0,0});
        // mod 0 up and down: tc every RUN cycle
        vq.push_back('{0,1,0,1,0,0, 0,0,0,0,0});
        vq.push_back('{0,0,0,0,0,0, 0,0,1,1,0});
        vq.push_back('{0,0,0,0,0,0, 0,1,1,1,0});
        vq.push_back('{0,0,1,0,0,0, 0,1,1,0,0});
        vq.push_back('{0,0,0,0,0,0, 0,0,0,0,0});
        vq.push_back('{0,1,0,0,0,0, 0,0,0,0,0});
        vq.push_back('{0,0,0,0,0,0, 0,0,1,0,0});
        vq.push_back('{0,0,0,0,0,0, 0,1,1,0,0});
        vq.push_back('{0,0,1,0,0,0, 0,1,1,0,0});
        // stop during LOAD returns to IDLE
        vq.push_back('{0,1,0,1,0,2, 0,0,0,0,0});
        vq.push_back('{0,0,1,0,0,0, 0,0,1,1,0});
        vq.push_back('{0,0,0,0,0,0, 0,0,0,0,0});

        for (int i = 0; i < vq.size(); i++) step(vq[i], $sformatf("vec%0d", i), 1'b0, 2'd0);

        // Bank disturbed above mod_lat while counting up with mod 1: wraps through 3 -> 0.
        step('{0,1,0,1,0,1, 0,0,0,0,0}, "dist_start", 1'b0, 2'd0);
        step('{0,0,0,0,0,0, 0,0,1,1,0}, "dist_load",  1'b0, 2'd0);
        step('{0,0,0,0,0,0, 0,0,1,0,1}, "dist_poke",  1'b1, 2'd3);
        step('{0,0,0,0,0,0, 3,0,1,0,3}, "dist_q3",    1'b0, 2'd0);
        step('{0,0,0,0,0,0, 0,0,1,0,1}, "dist_q0",    1'b0, 2'd0);
        step('{0,0,0,0,0,0, 1,1,1,1,0}, "dist_term",  1'b0, 2'd0);
        step('{0,0,1,0,0,0, 0,0,1,0,0}, "dist_stop",  1'b0, 2'd0);
        step('{0,0,0,0,0,0, 0,0,0,0,0}, "dist_idle",  1'b0, 2'd0);

        // One-shot up to 2: busy must drop exactly 5 edges after the start edge.
        step('{0,1,0,1,1,2, 0,0,0,0,0}, "os_start", 1'b0, 2'd0);
        n = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (!busy) break;
        end
        n_cmp++;
        if (n != 5 || busy) begin
            n_bad++;
            $display("FAIL os_latency: got %0d edges busy=%b, want 5 edges busy=0", n, busy);
        end
        n_cmp++;
        if (q_bank !== 2'd2) begin
            n_bad++;
            $display("FAIL os_hold_q: got q=%0d, want q=2", q_bank);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
